// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard unit.
//   fwd_sel_t       - E-stage forwarding mux select encoding
//   REG_ADDR_WIDTH_DEF - default register index width
//   MDU_LATENCY_MIN/MAX - legal range of the MDU issue-to-writeback latency
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_M  = 2'b01,
    FWD_W  = 2'b10
  } fwd_sel_t;

  localparam int REG_ADDR_WIDTH_DEF = 5;
  localparam int MDU_LATENCY_MIN    = 1;
  localparam int MDU_LATENCY_MAX    = 15;

endpackage

// File: rtl/hazard_scoreboard_chk.sv
// hazard_scoreboard_chk: simulation-only property checks for the hazard unit.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   mdu_start   MDU op issues from E
//   mdu_busy    scoreboard entry valid
//   mdu_wb      scoreboard writeback strobe
module hazard_scoreboard_chk
  import hazard_pkg::*;
#(
  parameter int MDU_LATENCY = 4
) (
  input logic clk,
  input logic rst,
  input logic mdu_start,
  input logic mdu_busy,
  input logic mdu_wb
);

  // Latency must lie in the range the countdown logic is built for.
  a_latency_range: assert property (@(posedge clk)
    (MDU_LATENCY >= MDU_LATENCY_MIN) && (MDU_LATENCY <= MDU_LATENCY_MAX));

  // The structural stall must keep a second op from issuing before the writeback cycle.
  a_no_start_while_busy: assert property (@(posedge clk) disable iff (rst)
    !(mdu_start && mdu_busy && !mdu_wb));

endmodule

// File: rtl/mdu_scoreboard.sv
// mdu_scoreboard: single-entry tracker for one outstanding MDU operation.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mdu_start       MDU op issues from E this cycle
//   start_rd        destination index of the issuing op
//   mdu_busy        entry valid
//   mdu_rd          destination of the pending op (0 when idle)
//   mdu_wb          writeback strobe, high in the final cycle of the op
module mdu_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int MDU_LATENCY    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mdu_start,
  input  logic [REG_ADDR_WIDTH-1:0] start_rd,
  output logic                      mdu_busy,
  output logic [REG_ADDR_WIDTH-1:0] mdu_rd,
  output logic                      mdu_wb
);

  localparam int CNT_WIDTH = $clog2(MDU_LATENCY + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(MDU_LATENCY);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [REG_ADDR_WIDTH-1:0] RD_ZERO = {REG_ADDR_WIDTH{1'b0}};

  logic                      busy_q, busy_d;
  logic [REG_ADDR_WIDTH-1:0] mdu_rd_q, mdu_rd_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      wb_s;

  assign wb_s = busy_q & (cnt_q == CNT_ONE);

  // Next-state: a new issue wins over the writeback clear so ops can run back to back.
  always_comb begin
    busy_d   = busy_q;
    mdu_rd_d = mdu_rd_q;
    cnt_d    = cnt_q;
    if (mdu_start) begin
      busy_d   = 1'b1;
      mdu_rd_d = start_rd;
      cnt_d    = CNT_LOAD;
    end else if (wb_s) begin
      busy_d   = 1'b0;
      mdu_rd_d = RD_ZERO;
      cnt_d    = CNT_ZERO;
    end else if (busy_q) begin
      cnt_d    = cnt_q - CNT_ONE;
    end else begin
      busy_d   = 1'b0;
      mdu_rd_d = mdu_rd_q;
      cnt_d    = cnt_q;
    end
  end

  // Scoreboard state register; reset discards any pending op.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      mdu_rd_q <= RD_ZERO;
      cnt_q    <= CNT_ZERO;
    end else begin
      busy_q   <= busy_d;
      mdu_rd_q <= mdu_rd_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mdu_busy = busy_q;
  assign mdu_rd   = mdu_rd_q;
  assign mdu_wb   = wb_s;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: hazard unit for the 5-stage RV32 pipeline.
//   E-stage forwarding from M/W, load-use and MDU scoreboard stalls,
//   branch/jump flush, and optional performance counters.
// Optional feature macro: HAZARD_PERF_EN (stall/flush counters; tied to 0 when undefined).
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   rs1_d, rs2_d, rd_d, *_used_d,
//   reg_write_d, mdu_op_d             D-stage instruction
//   rs1_e, rs2_e, rd_e, pc_src_e,
//   res_src_e_b0, mdu_start_e         E-stage instruction
//   rd_m/reg_write_m, rd_w/reg_write_w  M/W writers
//   stall_f, stall_d, flush_d, flush_e  pipeline register controls
//   forward_a_e, forward_b_e          forwarding selects (hazard_pkg::fwd_sel_t)
//   mdu_busy, mdu_rd, mdu_wb          scoreboard state and writeback strobe
//   stall_cnt, flush_cnt              performance counters
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int MDU_LATENCY    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] rd_d,
  input  logic                      rs1_used_d,
  input  logic                      rs2_used_d,
  input  logic                      reg_write_d,
  input  logic                      mdu_op_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_e,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_e,
  input  logic [REG_ADDR_WIDTH-1:0] rd_e,
  input  logic                      pc_src_e,
  input  logic                      res_src_e_b0,
  input  logic                      mdu_start_e,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m,
  input  logic                      reg_write_m,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w,
  input  logic                      reg_write_w,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic [1:0]                forward_a_e,
  output logic [1:0]                forward_b_e,
  output logic                      mdu_busy,
  output logic [REG_ADDR_WIDTH-1:0] mdu_rd,
  output logic                      mdu_wb,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               flush_cnt
);

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO = {REG_ADDR_WIDTH{1'b0}};

  logic src1_s, src2_s, long_e_s, sb_live_s;
  logic raw_e_s, raw_sb_s, waw_sb_s, struct_hz_s, stall_req_s, stall_s;

  mdu_scoreboard #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .MDU_LATENCY   (MDU_LATENCY)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .mdu_start(mdu_start_e),
    .start_rd (rd_e),
    .mdu_busy (mdu_busy),
    .mdu_rd   (mdu_rd),
    .mdu_wb   (mdu_wb)
  );

  hazard_scoreboard_chk #(
    .MDU_LATENCY(MDU_LATENCY)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .mdu_start(mdu_start_e),
    .mdu_busy (mdu_busy),
    .mdu_wb   (mdu_wb)
  );

  // M has the younger result, so it wins over W; x0 is never forwarded.
  function automatic fwd_sel_t fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs);
    if (reg_write_m && (rd_m != ZERO) && (rd_m == rs)) begin
      return FWD_M;
    end else if (reg_write_w && (rd_w != ZERO) && (rd_w == rs)) begin
      return FWD_W;
    end else begin
      return FWD_RF;
    end
  endfunction

  // Forwarding mux selects for both E-stage operands.
  always_comb begin
    forward_a_e = fwd_sel(rs1_e);
    forward_b_e = fwd_sel(rs2_e);
  end

  assign src1_s    = rs1_used_d & (rs1_d != ZERO);
  assign src2_s    = rs2_used_d & (rs2_d != ZERO);
  assign long_e_s  = res_src_e_b0 | mdu_start_e;
  // In the writeback cycle the write-first regfile already supplies the result.
  assign sb_live_s = mdu_busy & ~mdu_wb;

  assign raw_e_s     = long_e_s & (rd_e != ZERO) &
                       ((src1_s & (rs1_d == rd_e)) | (src2_s & (rs2_d == rd_e)));
  assign raw_sb_s    = sb_live_s & (mdu_rd != ZERO) &
                       ((src1_s & (rs1_d == mdu_rd)) | (src2_s & (rs2_d == mdu_rd)));
  assign waw_sb_s    = sb_live_s & reg_write_d & (rd_d == mdu_rd) & (rd_d != ZERO);
  assign struct_hz_s = mdu_op_d & (mdu_start_e | sb_live_s);
  assign stall_req_s = raw_e_s | raw_sb_s | waw_sb_s | struct_hz_s;

  // A taken branch makes the D instruction wrong-path, so it overrides the stall.
  assign stall_s = stall_req_s & ~pc_src_e;
  assign stall_f = stall_s;
  assign stall_d = stall_s;
  assign flush_d = pc_src_e;
  assign flush_e = stall_req_s | pc_src_e;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Counter increments; both wrap naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_s) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (pc_src_e) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       rs1_used_d, rs2_used_d, reg_write_d, mdu_op_d;
  logic       pc_src_e, res_src_e_b0, mdu_start_e, reg_write_m, reg_write_w;
  logic       stall_f, stall_d, flush_d, flush_e, mdu_busy, mdu_wb;
  logic [1:0] forward_a_e, forward_b_e;
  logic [4:0] mdu_rd;
  logic [31:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_ADDR_WIDTH(5), .MDU_LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d),
    .reg_write_d(reg_write_d), .mdu_op_d(mdu_op_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .pc_src_e(pc_src_e), .res_src_e_b0(res_src_e_b0), .mdu_start_e(mdu_start_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .mdu_busy(mdu_busy), .mdu_rd(mdu_rd), .mdu_wb(mdu_wb),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic        stall;
    logic        fd;
    logic        fe;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        busy;
    logic [4:0]  rd;
    logic        wb;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  logic [31:0] m_scnt = 32'd0;
  logic [31:0] m_fcnt = 32'd0;

  task automatic clr_in();
    rs1_d = 5'd0; rs2_d = 5'd0; rd_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0; rd_e = 5'd0;
    rd_m = 5'd0; rd_w = 5'd0; rs1_used_d = 1'b0; rs2_used_d = 1'b0;
    reg_write_d = 1'b0; mdu_op_d = 1'b0; pc_src_e = 1'b0; res_src_e_b0 = 1'b0;
    mdu_start_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
  endtask

  // Push the hand-computed expectation for the current cycle, then advance one cycle.
  task automatic chk(input string nm, input logic s, input logic fd, input logic fe,
                     input logic [1:0] fa, input logic [1:0] fb,
                     input logic busy, input logic [4:0] rd, input logic wb);
    exp_t e;
    e.stall = s; e.fd = fd; e.fe = fe; e.fa = fa; e.fb = fb;
    e.busy = busy; e.rd = rd; e.wb = wb;
`ifdef HAZARD_PERF_EN
    e.scnt = m_scnt; e.fcnt = m_fcnt;
`else
    e.scnt = 32'd0; e.fcnt = 32'd0;
`endif
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (rst) begin
      m_scnt = 32'd0; m_fcnt = 32'd0;
    end else begin
      m_scnt = m_scnt + {31'd0, s};
      m_fcnt = m_fcnt + {31'd0, pc_src_e};
    end
    @(posedge clk); #1;
  endtask

  task automatic cmp(input string nm, input string f, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, f, act, req);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation mid-cycle.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        cmp(nm, "stall_f",   {31'd0, stall_f},     {31'd0, e.stall});
        cmp(nm, "stall_d",   {31'd0, stall_d},     {31'd0, e.stall});
        cmp(nm, "flush_d",   {31'd0, flush_d},     {31'd0, e.fd});
        cmp(nm, "flush_e",   {31'd0, flush_e},     {31'd0, e.fe});
        cmp(nm, "fwd_a",     {30'd0, forward_a_e}, {30'd0, e.fa});
        cmp(nm, "fwd_b",     {30'd0, forward_b_e}, {30'd0, e.fb});
        cmp(nm, "mdu_busy",  {31'd0, mdu_busy},    {31'd0, e.busy});
        cmp(nm, "mdu_rd",    {27'd0, mdu_rd},      {27'd0, e.rd});
        cmp(nm, "mdu_wb",    {31'd0, mdu_wb},      {31'd0, e.wb});
        cmp(nm, "stall_cnt", stall_cnt,            e.scnt);
        cmp(nm, "flush_cnt", flush_cnt,            e.fcnt);
      end
    end
  end

  initial begin
    rst = 1'b1;
    clr_in();
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0);
    rst = 1'b0;

    // Forwarding
    clr_in(); rd_m = 5'd5; reg_write_m = 1'b1; rd_w = 5'd5; reg_write_w = 1'b1;
    rs1_e = 5'd5; rs2_e = 5'd5;
    chk("fwd_m_prio", 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 5'd0, 1'b0);
    clr_in(); rd_m = 5'd0; reg_write_m = 1'b1; rd_w = 5'd5; reg_write_w = 1'b1;
    rs1_e = 5'd0; rs2_e = 5'd5;
    chk("fwd_x0_w", 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 5'd0, 1'b0);
    clr_in(); rd_m = 5'd5; reg_write_m = 1'b0; rd_w = 5'd5; reg_write_w = 1'b1;
    rs1_e = 5'd3; rs2_e = 5'd5;
    chk("fwd_m_nowr", 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 5'd0, 1'b0);

    // Load-use
    clr_in(); res_src_e_b0 = 1'b1; rd_e = 5'd7; rs2_d = 5'd7; rs2_used_d = 1'b1;
    chk("lu_stall", 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0);
    clr_in(); rs2_d = 5'd7; rs2_used_d = 1'b1;
    chk("lu_release", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0);
    clr_in(); res_src_e_b0 = 1'b1; rd_e = 5'd7; rs2_d = 5'd7; rs2_used_d = 1'b0;
    chk("lu_unused", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0);
    clr_in(); res_src_e_b0 = 1'b1; rd_e = 5'd0; rs1_d = 5'd0; rs1_used_d = 1'b1;
    chk("lu_x0", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0);

    // MDU RAW
    clr_in(); mdu_start_e = 1'b1; rd_e = 5'd9; rs1_d = 5'd9; rs1_used_d = 1'b1;
    chk("mraw_issue", 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0);
    clr_in(); rs1_d = 5'd9; rs1_used_d = 1'b1;
    chk("mraw_c4", 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 5'd9, 1'b0);
    chk("mraw_c3", 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 5'd9, 1'b0);
    chk("mraw_c2", 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 5'd9, 1'b0);
    chk("mraw_wb", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd9, 1'b1);
    clr_in();
    chk("mraw_done", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0);

    // Structural stall, then back-to-back issue in the writeback cycle
    clr_in(); mdu_start_e = 1'b1; rd_e = 5'd10; mdu_op_d = 1'b1; rd_d = 5'd11; reg_write_d = 1'b1;
    chk("st_issue", 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0);
    clr_in(); mdu_op_d = 1'b1; rd_d = 5'd11; reg_write_d = 1'b1;
    chk("st_c4", 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 5'd10, 1'b0);
    chk("st_c3", 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 5'd10, 1'b0);
    chk("st_c2", 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 5'd10, 1'b0);
    chk("st_wb", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd10, 1'b1);
    clr_in(); mdu_start_e = 1'b1; rd_e = 5'd11;
    chk("st_issue2", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0);
    clr_in();
    chk("st2_c4", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd11, 1'b0);
    chk("st2_c3", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd11, 1'b0);
    chk("st2_c2", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd11, 1'b0);
    clr_in(); mdu_start_e = 1'b1; rd_e = 5'd12;
    chk("b2b_wb", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd11, 1'b1);

    // Branch overrides the scoreboard RAW stall; the entry survives
    clr_in(); rs1_d = 5'd12; rs1_used_d = 1'b1; pc_src_e = 1'b1;
    chk("br_raw", 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 5'd12, 1'b0);
    clr_in(); reg_write_d = 1'b1; rd_d = 5'd12;
    chk("br_waw", 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 5'd12, 1'b0);
    clr_in();
    chk("br_c2", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd12, 1'b0);
    clr_in(); reg_write_d = 1'b1; rd_d = 5'd12;
    chk("br_wb", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd12, 1'b1);
    clr_in();
    chk("br_done", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0);

    // Reset mid-op discards the entry
    clr_in(); mdu_start_e = 1'b1; rd_e = 5'd13;
    chk("rs_issue", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0);
    clr_in();
    chk("rs_c4", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd13, 1'b0);
    chk("rs_c3", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd13, 1'b0);
    rst = 1'b1;
    chk("rs_c2", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd13, 1'b0);
    rst = 1'b0;
    chk("rs_after", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0);
    chk("rs_nowb1", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0);
    chk("rs_nowb2", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
